csi2_frame_ctrl: RTL and testbench

Frame-level controller for the CSI-2 receive path. It drives the `enable` input of the CSI-2-to-AXI4-Stream converter and monitors the converter's output stream for Frame Start (FS) and Frame End (FE) short packets on one virtual channel. Capture therefore starts and stops only on frame boundaries, and the block maintains frame and error statistics for the register file.

---
 rtl/csi2_pkg.sv | 34 +++
 rtl/csi2_frame_ctrl_if.sv | 10 +
 rtl/csi2_sat_cnt.sv | 21 ++
 rtl/csi2_frame_ctrl.sv | 130 +++++++++++++
 tb/tb_csi2_frame_ctrl.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: short-packet data types, frame FSM states and
// header field positions of the converter's first (header) beat.
package csi2_pkg;

    localparam logic [5:0] DT_FS = 6'h00;
    localparam logic [5:0] DT_FE = 6'h01;

    localparam int HDR_DT_LSB = 0;
    localparam int HDR_DT_W   = 6;
    localparam int HDR_VC_LSB = 6;
    localparam int HDR_VC_W   = 2;
    localparam int HDR_WC_LSB = 8;
    localparam int HDR_WC_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_FS = 2'd1,
        ST_RUN     = 2'd2,
        ST_STOP    = 2'd3
    } csi2_frame_state_t;

    function automatic logic [HDR_DT_W-1:0] hdr_dt(input logic [31:0] d);
        return d[HDR_DT_LSB +: HDR_DT_W];
    endfunction

    function automatic logic [HDR_VC_W-1:0] hdr_vc(input logic [31:0] d);
        return d[HDR_VC_LSB +: HDR_VC_W];
    endfunction

    function automatic logic [HDR_WC_W-1:0] hdr_wc(input logic [31:0] d);
        return d[HDR_WC_LSB +: HDR_WC_W];
    endfunction

endpackage

// File: rtl/csi2_frame_ctrl_if.sv
// Packet tap between the CSI-2-to-AXI4-Stream converter output and the
// frame controller. No tready: the controller only observes the stream.
interface csi2_frame_ctrl_if;
    logic        tvalid;
    logic [31:0] tdata;
    logic        tlast;

    modport master (output tvalid, output tdata, output tlast);
    modport slave  (input  tvalid, input  tdata, input  tlast);
endinterface

// File: rtl/csi2_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module csi2_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    // Count up until all-ones, then hold; reset and clear both force zero.
    always_ff @(posedge clk_i) begin
        if (srst_i || clr_i) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/csi2_frame_ctrl.sv
// Frame-level capture controller: gates the converter enable so capture
// starts and stops on frame boundaries, and keeps frame/error statistics.
module csi2_frame_ctrl
    import csi2_pkg::*;
#(
    parameter logic [1:0]  VC        = 2'd0,
    parameter int          CNT_WIDTH = 16,
    parameter logic [23:0] TIMEOUT   = 24'd10_000_000
) (
    input  logic                 clk_i,
    input  logic                 srst_i,
    input  logic                 run_i,
    input  logic                 cnt_clr_i,
    csi2_frame_ctrl_if.slave     pkt,
    input  logic                 phy_err_i,
    output logic                 enable_o,
    output logic                 frame_active_o,
    output logic                 frame_start_o,
    output logic                 frame_end_o,
    output logic                 sync_err_o,
    output logic [15:0]          frame_num_o,
    output logic [CNT_WIDTH-1:0] frame_cnt_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o,
    output logic [1:0]           state_o
);

    csi2_frame_state_t state_q, state_d;
    logic              first_beat_q;
    logic [23:0]       wd_q, wd_d;
    logic [15:0]       frame_num_d;
    logic              start_d, end_d, sync_d;
    logic              hdr, is_fs, is_fe, wd_hit;

    // A beat is a packet header when it follows a tlast (or reset).
    assign hdr    = pkt.tvalid && first_beat_q;
    assign is_fs  = hdr && (hdr_dt(pkt.tdata) == DT_FS) && (hdr_vc(pkt.tdata) == VC);
    assign is_fe  = hdr && (hdr_dt(pkt.tdata) == DT_FE) && (hdr_vc(pkt.tdata) == VC);
    assign wd_hit = (TIMEOUT != 24'd0) && (wd_q == TIMEOUT);

    // Next-state and pulse decode; FE beats FS beats watchdog inside a frame.
    always_comb begin
        state_d     = state_q;
        wd_d        = wd_q;
        frame_num_d = frame_num_o;
        start_d     = 1'b0;
        end_d       = 1'b0;
        sync_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (run_i) state_d = ST_WAIT_FS;
            end
            ST_WAIT_FS: begin
                if (!run_i) begin
                    state_d = ST_STOP;
                end else if (is_fs) begin
                    state_d     = ST_RUN;
                    start_d     = 1'b1;
                    frame_num_d = hdr_wc(pkt.tdata);
                    // The FS beat cycle is the first counted frame cycle.
                    wd_d        = 24'd1;
                end
            end
            ST_RUN: begin
                if (is_fe) begin
                    end_d   = 1'b1;
                    state_d = run_i ? ST_WAIT_FS : ST_STOP;
                end else if (is_fs) begin
                    // Missing FE: resynchronise on the new frame.
                    sync_d      = 1'b1;
                    start_d     = 1'b1;
                    frame_num_d = hdr_wc(pkt.tdata);
                    wd_d        = 24'd1;
                end else if (wd_hit) begin
                    sync_d  = 1'b1;
                    state_d = ST_WAIT_FS;
                end else if (wd_q != '1) begin
                    wd_d = wd_q + 24'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, header tracking and registered outputs.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q        <= ST_IDLE;
            first_beat_q   <= 1'b1;
            wd_q           <= '0;
            frame_num_o    <= '0;
            frame_start_o  <= 1'b0;
            frame_end_o    <= 1'b0;
            sync_err_o     <= 1'b0;
            enable_o       <= 1'b0;
            frame_active_o <= 1'b0;
        end else begin
            state_q        <= state_d;
            if (pkt.tvalid) first_beat_q <= pkt.tlast;
            wd_q           <= wd_d;
            frame_num_o    <= frame_num_d;
            frame_start_o  <= start_d;
            frame_end_o    <= end_d;
            sync_err_o     <= sync_d;
            enable_o       <= (state_d == ST_WAIT_FS) || (state_d == ST_RUN);
            frame_active_o <= (state_d == ST_RUN);
        end
    end

    assign state_o = state_q;

    csi2_sat_cnt #(.WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .clr_i  (cnt_clr_i),
        .inc_i  (end_d),
        .cnt_o  (frame_cnt_o)
    );

    // PHY and sync errors in the same cycle count once.
    csi2_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk_i  (clk_i),
        .srst_i (srst_i),
        .clr_i  (cnt_clr_i),
        .inc_i  (sync_d || phy_err_i),
        .cnt_o  (err_cnt_o)
    );

endmodule

// File: tb/tb_csi2_frame_ctrl.sv
// Bench for csi2_frame_ctrl: two instances (VC0/16-bit counters/TIMEOUT=100
// and VC1/2-bit counters/watchdog off) share one packet stream and are
// compared every cycle against a per-instance reference model.
module tb_csi2_frame_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst = 1'b1, run = 1'b0, clr = 1'b0, phy = 1'b0;
    csi2_frame_ctrl_if pkt_bus ();

    logic        en_a, act_a, fs_a, fe_a, se_a;
    logic [15:0] fnum_a, fcnt_a, ecnt_a;
    logic [1:0]  st_a;
    logic        en_b, act_b, fs_b, fe_b, se_b;
    logic [15:0] fnum_b;
    logic [1:0]  fcnt_b, ecnt_b, st_b;

    csi2_frame_ctrl #(.VC(2'd0), .CNT_WIDTH(16), .TIMEOUT(24'd100)) u_dut_a (
        .clk_i(clk), .srst_i(srst), .run_i(run), .cnt_clr_i(clr), .pkt(pkt_bus),
        .phy_err_i(phy), .enable_o(en_a), .frame_active_o(act_a),
        .frame_start_o(fs_a), .frame_end_o(fe_a), .sync_err_o(se_a),
        .frame_num_o(fnum_a), .frame_cnt_o(fcnt_a), .err_cnt_o(ecnt_a), .state_o(st_a)
    );

    csi2_frame_ctrl #(.VC(2'd1), .CNT_WIDTH(2), .TIMEOUT(24'd0)) u_dut_b (
        .clk_i(clk), .srst_i(srst), .run_i(run), .cnt_clr_i(clr), .pkt(pkt_bus),
        .phy_err_i(phy), .enable_o(en_b), .frame_active_o(act_b),
        .frame_start_o(fs_b), .frame_end_o(fe_b), .sync_err_o(se_b),
        .frame_num_o(fnum_b), .frame_cnt_o(fcnt_b), .err_cnt_o(ecnt_b), .state_o(st_b)
    );

    // Reference model state: phase 0 idle, 1 waiting for FS, 2 in frame, 3 stopping.
    typedef struct packed {
        int phase;
        bit at_hdr;
        bit en, act, fs, fe, se;
        int fnum, fcnt, ecnt, age;
    } ref_t;

    ref_t ma, mb;
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic ref_t ref_reset();
        ref_t r;
        r = '0;
        r.at_hdr = 1'b1;
        return r;
    endfunction

    function automatic ref_t ref_step(ref_t m, int vc, int cmax, int tmo,
                                      bit rst, bit r_run, bit r_clr, bit r_phy,
                                      bit tv, logic [31:0] td, bit tl);
        ref_t n;
        bit   fs_pkt, fe_pkt, done;
        int   dt, v;
        if (rst) return ref_reset();
        n = m; n.fs = 0; n.fe = 0; n.se = 0; done = 0;
        dt = int'(td[5:0]);
        v  = int'(td[7:6]);
        fs_pkt = tv && m.at_hdr && dt == 0 && v == vc;
        fe_pkt = tv && m.at_hdr && dt == 1 && v == vc;
        if (tv) n.at_hdr = tl;
        if (m.phase == 0) begin
            if (r_run) n.phase = 1;
        end else if (m.phase == 1) begin
            if (!r_run) n.phase = 3;
            else if (fs_pkt) begin
                n.phase = 2; n.fs = 1; n.fnum = int'(td[23:8]); n.age = 1;
            end
        end else if (m.phase == 2) begin
            if (fe_pkt) begin
                n.fe = 1; done = 1; n.phase = r_run ? 1 : 3;
            end else if (fs_pkt) begin
                n.se = 1; n.fs = 1; n.fnum = int'(td[23:8]); n.age = 1;
            end else if (tmo != 0 && m.age >= tmo) begin
                n.se = 1; n.phase = 1;
            end else begin
                n.age = (m.age + 1 > 24'hFFFFFF) ? 24'hFFFFFF : m.age + 1;
            end
        end else begin
            n.phase = 0;
        end
        if (r_clr) n.fcnt = 0;
        else if (done) n.fcnt = (m.fcnt + 1 > cmax) ? cmax : m.fcnt + 1;
        if (r_clr) n.ecnt = 0;
        else if (n.se || r_phy) n.ecnt = (m.ecnt + 1 > cmax) ? cmax : m.ecnt + 1;
        n.en  = (n.phase == 1) || (n.phase == 2);
        n.act = (n.phase == 2);
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("a.state", 32'(st_a), ma.phase);   chk("b.state", 32'(st_b), mb.phase);
        chk("a.enable", 32'(en_a), ma.en);     chk("b.enable", 32'(en_b), mb.en);
        chk("a.active", 32'(act_a), ma.act);   chk("b.active", 32'(act_b), mb.act);
        chk("a.fstart", 32'(fs_a), ma.fs);     chk("b.fstart", 32'(fs_b), mb.fs);
        chk("a.fend", 32'(fe_a), ma.fe);       chk("b.fend", 32'(fe_b), mb.fe);
        chk("a.syncerr", 32'(se_a), ma.se);    chk("b.syncerr", 32'(se_b), mb.se);
        chk("a.fnum", 32'(fnum_a), ma.fnum);   chk("b.fnum", 32'(fnum_b), mb.fnum);
        chk("a.fcnt", 32'(fcnt_a), ma.fcnt);   chk("b.fcnt", 32'(fcnt_b), mb.fcnt);
        chk("a.ecnt", 32'(ecnt_a), ma.ecnt);   chk("b.ecnt", 32'(ecnt_b), mb.ecnt);
    endtask

    // One clock: models advance with the DUTs, outputs compared at negedge.
    task automatic tick();
        @(posedge clk);
        ma = ref_step(ma, 0, 65535, 100, srst, run, clr, phy,
                      pkt_bus.tvalid, pkt_bus.tdata, pkt_bus.tlast);
        mb = ref_step(mb, 1, 3, 0, srst, run, clr, phy,
                      pkt_bus.tvalid, pkt_bus.tdata, pkt_bus.tlast);
        @(negedge clk);
        compare_all();
        clr = 1'b0;
        phy = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic beat(input logic [31:0] d, input bit last);
        pkt_bus.tvalid = 1'b1;
        pkt_bus.tdata  = d;
        pkt_bus.tlast  = last;
        tick();
        pkt_bus.tvalid = 1'b0;
        pkt_bus.tlast  = 1'b0;
        pkt_bus.tdata  = $urandom;
    endtask

    task automatic short_pkt(input int dt, input int vc, input int wc);
        logic [31:0] d;
        d = {8'($urandom_range(0, 255)), 16'(wc), 2'(vc), 6'(dt)};
        beat(d, 1'b1);
    endtask

    // Long packet: header beat, then payload; payload may mimic an FS header.
    task automatic long_pkt(input int nbeats, input bit fake_fs);
        logic [31:0] d;
        d = {8'h00, 16'(nbeats * 4), 2'($urandom_range(0, 3)), 6'h2A};
        beat(d, 1'b0);
        for (int i = 0; i < nbeats; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            d = fake_fs ? 32'h0000_0540 : 32'($urandom);
            if (fake_fs && i == 1) d = 32'h0000_0500;
            beat(d, i == nbeats - 1);
        end
    endtask

    function automatic int pick_dt();
        int s;
        s = $urandom_range(0, 3);
        return (s == 0) ? 0 : (s == 1) ? 1 : (s == 2) ? 'h2A : 'h12;
    endfunction

    initial begin
        int k;
        pkt_bus.tvalid = 1'b0;
        pkt_bus.tdata  = '0;
        pkt_bus.tlast  = 1'b0;
        ma = ref_reset();
        mb = ref_reset();

        // Reset
        srst = 1'b1;
        idle(3);
        srst = 1'b0;
        chk("rst.state", 32'(st_a), 0);
        chk("rst.enable", 32'(en_a), 0);
        chk("rst.fcnt", 32'(fcnt_a), 0);
        tick();

        // Basic frame on VC0
        run = 1'b1;
        tick();
        chk("run.enable", 32'(en_a), 1);
        short_pkt(0, 0, 5);
        chk("fs.pulse", 32'(fs_a), 1);
        chk("fs.num", 32'(fnum_a), 5);
        chk("fs.active", 32'(act_a), 1);
        for (int i = 0; i < 3; i++) long_pkt(3, 1'b0);
        short_pkt(1, 0, 5);
        chk("fe.pulse", 32'(fe_a), 1);
        chk("fe.fcnt", 32'(fcnt_a), 1);
        chk("fe.ecnt", 32'(ecnt_a), 0);

        // run dropped mid-frame
        short_pkt(0, 0, 6);
        run = 1'b0;
        long_pkt(4, 1'b0);
        chk("stop.enable_held", 32'(en_a), 1);
        short_pkt(1, 0, 6);
        chk("stop.enable_low", 32'(en_a), 0);
        tick();
        chk("stop.idle", 32'(st_a), 0);
        short_pkt(0, 0, 7);
        chk("stop.fs_ignored", 32'(fs_a), 0);

        // FS without FE
        run = 1'b1;
        tick();
        short_pkt(0, 0, 10);
        idle(2);
        short_pkt(0, 0, 11);
        chk("dupfs.syncerr", 32'(se_a), 1);
        chk("dupfs.start", 32'(fs_a), 1);
        chk("dupfs.ecnt", 32'(ecnt_a), 1);
        chk("dupfs.state", 32'(st_a), 2);
        short_pkt(1, 0, 11);

        // Foreign VC and FS-looking payload
        short_pkt(0, 1, 12);
        chk("vc1.fs_ignored", 32'(fs_a), 0);
        short_pkt(1, 1, 12);
        long_pkt(4, 1'b1);
        chk("payload.state", 32'(st_a), 1);

        // Watchdog on instance A
        short_pkt(0, 0, 20);
        k = 1;
        while (!se_a && k < 200) begin
            tick();
            k++;
        end
        chk("wd.cycle", k, 101);
        chk("wd.state", 32'(st_a), 1);

        // Saturation and clear on instance B
        for (int i = 0; i < 5; i++) begin
            short_pkt(0, 1, 30 + i);
            long_pkt(2, 1'b0);
            short_pkt(1, 1, 30 + i);
        end
        chk("sat.fcnt", 32'(fcnt_b), 3);
        short_pkt(0, 1, 40);
        chk("sat.hold", 32'(fcnt_b), 3);
        clr = 1'b1;
        short_pkt(1, 1, 40);
        chk("clr.fcnt", 32'(fcnt_b), 0);
        clr = 1'b1;
        tick();
        short_pkt(0, 1, 41);
        phy = 1'b1;
        short_pkt(0, 1, 42);
        chk("physync.syncerr", 32'(se_b), 1);
        chk("physync.ecnt", 32'(ecnt_b), 1);
        short_pkt(1, 1, 42);

        // Randomized traffic
        for (int it = 0; it < 400; it++) begin
            int a;
            a = $urandom_range(0, 99);
            if (a < 6) run = ~run;
            if ($urandom_range(0, 19) == 0) clr = 1'b1;
            if ($urandom_range(0, 9) == 0) phy = 1'b1;
            if (a < 2) begin
                srst = 1'b1;
                tick();
                srst = 1'b0;
            end else if (a < 35) begin
                short_pkt(pick_dt(), $urandom_range(0, 2), $urandom_range(0, 65535));
            end else if (a < 65) begin
                long_pkt($urandom_range(1, 6), 1'($urandom_range(0, 1)));
            end else if (a < 68) begin
                idle(110);
            end else begin
                idle($urandom_range(1, 4));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
